// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and an optional
// iterative shift-add multiplier; results are held until the consumer takes them.
module alu_seq #(
    parameter int unsigned WIDTH  = 4,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             co,
    output logic             zf,
    output logic             busy
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               r_state, w_state_next;
    logic [2*WIDTH-1:0]   r_mcand, w_mcand_next;
    logic [WIDTH-1:0]     r_mplier, w_mplier_next;
    logic [2*WIDTH-1:0]   r_acc, w_acc_next;
    logic [CntW-1:0]      r_cnt, w_cnt_next;
    logic [WIDTH-1:0]     r_c, w_c_next;
    logic                 r_co, w_co_next;
    logic                 r_zf, w_zf_next;

    logic [WIDTH-1:0]     w_alu_c;
    logic                 w_alu_co;
    logic [2*WIDTH-1:0]   w_step;
    logic                 w_is_mul;

    // Single-cycle ops; op 110 lands here only when the multiplier is disabled.
    always_comb begin
        w_alu_c  = '0;
        w_alu_co = 1'b0;
        case (op)
            3'b000: w_alu_c = ~a;
            3'b001: w_alu_c = a & b;
            3'b010: w_alu_c = a | b;
            3'b011: w_alu_c = a ^ b;
            3'b100: {w_alu_co, w_alu_c} = {1'b0, a} + {1'b0, b};
            3'b101: begin
                w_alu_c  = a - b;
                w_alu_co = (a < b);
            end
            3'b110: w_alu_c = '0;
            3'b111: w_alu_c = '0;
            default: w_alu_c = '0;
        endcase
    end

    assign w_is_mul = MUL_EN && (op == 3'b110);
    assign w_step   = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_state_next  = r_state;
        w_mcand_next  = r_mcand;
        w_mplier_next = r_mplier;
        w_acc_next    = r_acc;
        w_cnt_next    = r_cnt;
        w_c_next      = r_c;
        w_co_next     = r_co;
        w_zf_next     = r_zf;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    if (w_is_mul) begin
                        w_mcand_next  = {{WIDTH{1'b0}}, a};
                        w_mplier_next = b;
                        w_acc_next    = '0;
                        w_cnt_next    = '0;
                        w_state_next  = StMul;
                    end else begin
                        w_c_next     = w_alu_c;
                        w_co_next    = w_alu_co;
                        w_zf_next    = (w_alu_c == '0);
                        w_state_next = StDone;
                    end
                end
            end
            StMul: begin
                w_acc_next    = w_step;
                w_mcand_next  = r_mcand << 1;
                w_mplier_next = r_mplier >> 1;
                w_cnt_next    = r_cnt + 1'b1;
                if (r_cnt == CntLast) begin
                    w_c_next     = w_step[WIDTH-1:0];
                    w_co_next    = |w_step[2*WIDTH-1:WIDTH];
                    w_zf_next    = (w_step[WIDTH-1:0] == '0);
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_c      <= '0;
            r_co     <= 1'b0;
            r_zf     <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_mcand  <= w_mcand_next;
            r_mplier <= w_mplier_next;
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            r_c      <= w_c_next;
            r_co     <= w_co_next;
            r_zf     <= w_zf_next;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state == StMul);
    assign c         = r_c;
    assign co        = r_co;
    assign zf        = r_zf;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected {c,co,zf}, a monitor pops
// and compares on every output handshake; a second instance covers MUL_EN=0.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_valid0 = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [2:0] op = '0;

    logic       in_ready, out_valid, co, zf, busy;
    logic [3:0] c;
    logic       in_ready0, out_valid0, co0, zf0, busy0;
    logic [3:0] c0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(4), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .co(co), .zf(zf), .busy(busy)
    );

    alu_seq #(.WIDTH(4), .MUL_EN(1'b0)) u_dut_nomul (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
        .c(c0), .co(co0), .zf(zf0), .busy(busy0)
    );

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: every handshake on the main instance must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected result", 1, 0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("result c", int'(c), int'(e[5:2]));
                check("result co", int'(co), int'(e[1]));
                check("result zf", int'(zf), int'(e[0]));
            end
        end
    end

    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] iop,
                          input logic [3:0] ec, input logic eco, input logic ezf,
                          input int elat, input string name);
        int waited = 0;
        int lat = 0;
        int busy_n = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check({name, " ready timeout"}, 0, 1);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        exp_q.push_back({ec, eco, ezf});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ia; b = ~ib; op = ~iop;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (out_valid) break;
        end
        check({name, " latency"}, lat, elat);
        check({name, " busy cycles"}, busy_n, elat - 1);
        @(posedge clk);
    endtask

    initial begin
        // 1: reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst out_valid", int'(out_valid), 0);
        check("rst c", int'(c), 0);
        check("rst co", int'(co), 0);
        check("rst zf", int'(zf), 1);
        check("rst in_ready", int'(in_ready), 1);
        check("rst busy", int'(busy), 0);

        // 2: add with carry, not
        run_op(4'b1110, 4'b0100, 3'b100, 4'b0010, 1'b1, 1'b0, 1, "add");
        run_op(4'b1110, 4'b0000, 3'b000, 4'b0001, 1'b0, 1'b0, 1, "not");
        run_op(4'b1100, 4'b1010, 3'b001, 4'b1000, 1'b0, 1'b0, 1, "and");
        run_op(4'b1100, 4'b1010, 3'b010, 4'b1110, 1'b0, 1'b0, 1, "or");
        run_op(4'b1100, 4'b1010, 3'b011, 4'b0110, 1'b0, 1'b0, 1, "xor");
        run_op(4'b1100, 4'b1010, 3'b111, 4'b0000, 1'b0, 1'b1, 1, "zero");

        // 3: subtract with borrow, subtract to zero
        run_op(4'b0011, 4'b0101, 3'b101, 4'b1110, 1'b1, 1'b0, 1, "sub borrow");
        run_op(4'b0101, 4'b0101, 3'b101, 4'b0000, 1'b0, 1'b1, 1, "sub zero");

        // 4: multiply 5*3=15, 15*15=225 (0xE1)
        run_op(4'b0101, 4'b0011, 3'b110, 4'b1111, 1'b0, 1'b0, 5, "mul");
        run_op(4'b1111, 4'b1111, 3'b110, 4'b0001, 1'b1, 1'b0, 5, "mul ovf");

        // 5: consumer stall while a new op is offered
        @(negedge clk);
        a = 4'b0011; b = 4'b0100; op = 3'b100; in_valid = 1'b1; out_ready = 1'b0;
        exp_q.push_back({4'b0111, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        a = 4'b1111; b = 4'b1111; op = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall out_valid", int'(out_valid), 1);
            check("stall in_ready", int'(in_ready), 0);
            check("stall c", int'(c), 4'b0111);
            check("stall co", int'(co), 0);
            check("stall zf", int'(zf), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("release in_ready", int'(in_ready), 1);
        check("release out_valid", int'(out_valid), 0);
        repeat (3) @(negedge clk);
        check("new op not taken", int'(out_valid), 0);

        // 6: reset on the 2nd cycle of a multiply
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; op = 3'b110; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("mul busy before rst", int'(busy), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort in_ready", int'(in_ready), 1);
        check("abort out_valid", int'(out_valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort c", int'(c), 0);
        check("abort co", int'(co), 0);
        check("abort zf", int'(zf), 1);
        repeat (10) @(negedge clk);
        check("abort no result", int'(out_valid), 0);

        // MUL_EN=0: op 110 acts as zero
        a = 4'b0101; b = 4'b0011; op = 3'b110; in_valid0 = 1'b1;
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        @(negedge clk);
        check("nomul out_valid", int'(out_valid0), 1);
        check("nomul busy", int'(busy0), 0);
        check("nomul c", int'(c0), 0);
        check("nomul co", int'(co0), 0);
        check("nomul zf", int'(zf0), 1);
        repeat (2) @(negedge clk);

        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
